param_decimator: RTL and testbench
==================================

// Module: param_decimator
// PURPOSE
//   Parametrised successor of the fixed-ratio down sampler: integer-factor decimator with valid handshake.
//   Sits between the receive filter chain and symbol-rate logic in the CLOCK_50 domain.
//   Decimation factor is runtime-selectable in 1..MAX_FACTOR.
//   Two modes: DROP (keep every Nth accepted sample) and INTEG (integrate-and-dump sum of N samples).
// PARAMETERS
//   DATA_W      16  input sample width, signed two's complement
//   MAX_FACTOR  16  largest supported decimation factor (>=2)
//   FACT_W      $clog2(MAX_FACTOR+1)  width of factor port (derived, do not override)
//   OUT_W       DATA_W+$clog2(MAX_FACTOR)  output width; holds a full INTEG sum without overflow
// PORTS
//   CLOCK_50       in   1       system clock; all logic on rising edge
//   reset          in   1       synchronous, active-high reset
//   in_valid       in   1       data_in holds a new sample this cycle
//   data_in        in   DATA_W  signed input sample
//   factor         in   FACT_W  requested decimation factor
//   mode           in   1       0 = DROP, 1 = INTEG
//   out_valid      out  1       one-cycle pulse; down_data_out updated this cycle
//   down_data_out  out  OUT_W   signed decimated sample, held between pulses
//   cfg_err        out  1       latched factor was out of range (sticky until reset)
// BEHAVIOUR
//   Reset (synchronous, highest priority): phase=0, acc=0, out_valid=0, down_data_out=0, cfg_err=0;
//     act_factor/act_mode load the sanitised factor/mode inputs on the same edge.
//   Sanitise: factor==0 -> 1; factor>MAX_FACTOR -> MAX_FACTOR; either case sets cfg_err.
//   Only edges with in_valid=1 advance state; with in_valid=0 phase, acc and outputs hold; out_valid=0.
//   Phase counter counts accepted samples 0..act_factor-1 and wraps to 0 on the terminal sample.
//   Terminal sample = in_valid while phase==act_factor-1. On that edge:
//     DROP : down_data_out <= sign-extend(data_in)   (the Nth accepted sample, not the 1st)
//     INTEG: down_data_out <= acc + sign-extend(data_in); acc <= 0
//     out_valid <= 1 for exactly one cycle. Latency: one edge after the terminal sample is accepted.
//   Non-terminal accepted sample: INTEG acc <= acc + sign-extend(data_in); DROP acc is unused, held at 0.
//   act_factor/act_mode reload only on a terminal edge (frame boundary) or reset; changes mid-frame
//     take effect from the next frame, never truncating the current one.
//   act_factor==1: every accepted sample is terminal; out_valid mirrors in_valid delayed by one cycle.
//   Back-to-back terminals (factor 1, continuous valid) give out_valid high on consecutive cycles.
//   Arithmetic: signed, full precision, no saturation; OUT_W guarantees no wrap for N<=MAX_FACTOR.
//   Reset asserted mid-frame discards partial phase/acc; no output is produced for the partial frame.
// STRUCTURE
//   Shared package dsp_pkg: MODE_DROP=1'b0, MODE_INTEG=1'b1, width-derivation functions (clog2).
//   Sub-module decim_phase_ctr: phase counter + act_factor latch + sanitise + terminal/cfg_err flags.
//   Top level holds accumulator, mode latch and output registers.
// TESTING
//   1 DROP, factor=6, continuous valid, data_in 100,200,..,2000 -> outputs 600,1200,1800; no 4th pulse.
//   2 INTEG, factor=4, data 1..8 -> outputs 10 then 26; factor=16, 16 x -32768 -> -524288, no wrap.
//   3 DROP, factor=3, in_valid toggled 1,0,1,0,1 with data 5,x,6,x,7 -> single output 7, gaps ignored.
//   4 factor 6->2 after 2nd sample of a frame -> current frame still emits 6th sample; next frames every 2.
//   5 factor=0 -> pass-through (every sample) + cfg_err=1; factor=20 -> decimate by 16, cfg_err=1.
//   6 reset pulse after 3 of 6 samples -> outputs 0, out_valid=0; next output is 6th sample after reset.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: decimator mode encodings and width-derivation helpers.
package dsp_pkg;

  localparam logic MODE_DROP  = 1'b0;
  localparam logic MODE_INTEG = 1'b1;

  // Smallest r with 2**r >= v; usable in constant expressions for port widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_decimator_if.sv
// Sample-stream bundle between the receive filter chain and the decimator.
interface param_decimator_if #(
  parameter int DATA_W     = 16,
  parameter int MAX_FACTOR = 16
);
  localparam int FACT_W = dsp_pkg::clog2(MAX_FACTOR + 1);
  localparam int OUT_W  = DATA_W + dsp_pkg::clog2(MAX_FACTOR);

  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic [FACT_W-1:0]        factor;
  logic                     mode;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  down_data_out;
  logic                     cfg_err;

  modport master (
    output in_valid, data_in, factor, mode,
    input  out_valid, down_data_out, cfg_err
  );

  modport slave (
    input  in_valid, data_in, factor, mode,
    output out_valid, down_data_out, cfg_err
  );
endinterface

// File: rtl/param_decimator_phase_ctr.sv
// Frame phase counter: latches the sanitised factor at frame boundaries and flags the terminal sample.
module decim_phase_ctr #(
  parameter int MAX_FACTOR = 16,
  parameter int FACT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FACT_W-1:0] factor,
  output logic              terminal,
  output logic              cfg_err
);

  logic [FACT_W-1:0] phase;
  logic [FACT_W-1:0] act_factor;

  function automatic logic out_of_range(input logic [FACT_W-1:0] f);
    return (f == '0) || (f > FACT_W'(MAX_FACTOR));
  endfunction

  function automatic logic [FACT_W-1:0] sanitise(input logic [FACT_W-1:0] f);
    if (f == '0) return FACT_W'(1);
    if (f > FACT_W'(MAX_FACTOR)) return FACT_W'(MAX_FACTOR);
    return f;
  endfunction

  assign terminal = in_valid && (phase == act_factor - FACT_W'(1));

  // Factor is only re-sampled on the terminal edge so a running frame is never truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      act_factor <= sanitise(factor);
      cfg_err    <= 1'b0;
    end else if (in_valid) begin
      if (terminal) begin
        phase      <= '0;
        act_factor <= sanitise(factor);
        if (out_of_range(factor)) cfg_err <= 1'b1;
      end else begin
        phase <= phase + FACT_W'(1);
      end
    end
  end

endmodule

// File: rtl/param_decimator.sv
// Integer-factor decimator (DROP or integrate-and-dump) with valid handshake, runtime factor 1..MAX_FACTOR.
module param_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MAX_FACTOR = 16,
  localparam int FACT_W    = clog2(MAX_FACTOR + 1),
  localparam int OUT_W     = DATA_W + clog2(MAX_FACTOR)
) (
  input logic               CLOCK_50,
  input logic               reset,
  param_decimator_if.slave  bus
);

  logic                    terminal;
  logic                    act_mode;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] sample_ext;

  assign sample_ext = {{(OUT_W - DATA_W){bus.data_in[DATA_W-1]}}, bus.data_in};

  decim_phase_ctr #(
    .MAX_FACTOR (MAX_FACTOR),
    .FACT_W     (FACT_W)
  ) u_phase_ctr (
    .clk      (CLOCK_50),
    .rst      (reset),
    .in_valid (bus.in_valid),
    .factor   (bus.factor),
    .terminal (terminal),
    .cfg_err  (bus.cfg_err)
  );

  // Output stage: one edge after the terminal sample; acc stays at zero in DROP mode.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc               <= '0;
      act_mode          <= bus.mode;
      bus.out_valid     <= 1'b0;
      bus.down_data_out <= '0;
    end else begin
      bus.out_valid <= terminal;
      if (terminal) begin
        bus.down_data_out <= (act_mode == MODE_INTEG) ? acc + sample_ext : sample_ext;
        acc               <= '0;
        act_mode          <= bus.mode;
      end else if (bus.in_valid && act_mode == MODE_INTEG) begin
        acc <= acc + sample_ext;
      end
    end
  end

endmodule

// File: tb/tb_param_decimator.sv
// Scoreboard bench for param_decimator: frame-level reference model feeds an expected queue, monitor compares pulses.
module tb_param_decimator;

  localparam int DATA_W     = 16;
  localparam int MAX_FACTOR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  param_decimator_if #(.DATA_W(DATA_W), .MAX_FACTOR(MAX_FACTOR)) bus ();

  param_decimator #(.DATA_W(DATA_W), .MAX_FACTOR(MAX_FACTOR)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    longint data;
    bit     err;
  } exp_t;

  exp_t   exp_q[$];
  longint frame_q[$];
  int     frame_n;
  bit     frame_mode;
  bit     model_err;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int san(input int f);
    if (f == 0) return 1;
    if (f > MAX_FACTOR) return MAX_FACTOR;
    return f;
  endfunction

  // Reference: collect a frame of accepted samples, emit last (DROP) or sum (INTEG) when it is full.
  task automatic apply(input bit v, input int d, input int f, input bit m);
    longint s;
    bus.in_valid = v;
    bus.data_in  = 16'(d);
    bus.factor   = 5'(f);
    bus.mode     = m;
    if (v) begin
      frame_q.push_back(longint'(d));
      if (frame_q.size() == frame_n) begin
        s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        if (f == 0 || f > MAX_FACTOR) model_err = 1'b1;
        exp_q.push_back('{data: (frame_mode ? s : frame_q[$]), err: model_err});
        frame_q.delete();
        frame_n    = san(f);
        frame_mode = m;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int f, input bit m);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.factor   = 5'(f);
    bus.mode     = m;
    frame_q.delete();
    frame_n    = san(f);
    frame_mode = m;
    model_err  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_data", longint'(bus.down_data_out), 0);
    chk("reset_cfg_err", longint'(bus.cfg_err), 0);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", longint'(bus.down_data_out), e.data);
        chk("out_cfg_err", longint'(bus.cfg_err), longint'(e.err));
      end
    end
  end

  initial begin
    int f;
    bit m;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.factor   = 5'd1;
    bus.mode     = 1'b0;
    @(posedge clk);
    #1;

    // 1: DROP by 6, 20 samples
    do_reset(6, 1'b0);
    for (int i = 1; i <= 20; i++) apply(1'b1, i * 100, 6, 1'b0);
    apply(1'b0, 0, 6, 1'b0);
    chk("t1_held", longint'(bus.down_data_out), 1800);

    // 2: INTEG by 4, then full-scale negative INTEG by 16
    do_reset(4, 1'b1);
    for (int i = 1; i <= 8; i++) apply(1'b1, i, 4, 1'b1);
    do_reset(16, 1'b1);
    for (int i = 0; i < 16; i++) apply(1'b1, -32768, 16, 1'b1);
    apply(1'b0, 0, 16, 1'b1);
    chk("t2_no_wrap", longint'(bus.down_data_out), -524288);

    // 3: DROP by 3 with gaps
    do_reset(3, 1'b0);
    apply(1'b1, 5, 3, 1'b0);
    apply(1'b0, 99, 3, 1'b0);
    apply(1'b1, 6, 3, 1'b0);
    apply(1'b0, 99, 3, 1'b0);
    apply(1'b1, 7, 3, 1'b0);
    apply(1'b0, 0, 3, 1'b0);

    // 4: factor change mid-frame
    do_reset(6, 1'b0);
    for (int i = 1; i <= 2; i++) apply(1'b1, i, 6, 1'b0);
    for (int i = 3; i <= 10; i++) apply(1'b1, i, 2, 1'b0);

    // 5: out-of-range factors
    do_reset(0, 1'b0);
    for (int i = 1; i <= 4; i++) apply(1'b1, -i, 0, 1'b0);
    chk("t5_cfg_err_low", longint'(bus.cfg_err), 1);
    do_reset(20, 1'b0);
    for (int i = 1; i <= 17; i++) apply(1'b1, i * 3, 20, 1'b0);
    apply(1'b0, 0, 20, 1'b0);
    chk("t5_cfg_err_high", longint'(bus.cfg_err), 1);

    // 6: reset mid-frame
    do_reset(6, 1'b0);
    for (int i = 1; i <= 3; i++) apply(1'b1, i, 6, 1'b0);
    do_reset(6, 1'b0);
    for (int i = 11; i <= 16; i++) apply(1'b1, i, 6, 1'b0);

    // Random: mixed valid, factors 0..20, mode switches, rare resets
    f = $urandom_range(1, MAX_FACTOR);
    m = 1'($urandom_range(0, 1));
    do_reset(f, m);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) f = $urandom_range(0, 20);
      if ($urandom_range(0, 29) == 0) m = ~m;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(f, m);
      end else begin
        apply($urandom_range(0, 9) < 7, int'($signed(16'($urandom))), f, m);
      end
    end

    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
